// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple subtractor: diff = a - b - bin, one bit per clock through a
// single full-subtractor cell and borrow flop, with valid/ready on both sides.
module serial_ripple_subtractor #(
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout
);

   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q;
   logic [N-1:0]    a_sh_q;
   logic [N-1:0]    b_sh_q;
   logic [N-1:0]    res_q;
   logic [N-1:0]    diff_q;
   logic [CW-1:0]   cnt_q;
   logic            br_q;
   logic            bout_q;
   logic            in_ready_q;
   logic            out_valid_q;

   logic            a0;
   logic            b0;
   logic            d_bit;
   logic            br_d;
   logic [N-1:0]    res_d;

   // Full-subtractor cell on the current LSBs; result bit enters at the MSB.
   assign a0    = a_sh_q[0];
   assign b0    = b_sh_q[0];
   assign d_bit = a0 ^ b0 ^ br_q;
   assign br_d  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
   assign res_d = N'({d_bit, res_q} >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         br_q        <= 1'b0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_sh_q     <= a;
                  b_sh_q     <= b;
                  br_q       <= bin;
                  res_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               br_q   <= br_d;
               res_q  <= res_d;
               cnt_q  <= cnt_q + CW'(1);
               // Last bit: capture the completed result and the final borrow.
               if (cnt_q == CW'(N - 1)) begin
                  diff_q      <= res_d;
                  bout_q      <= br_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor against an arithmetic model.
module tb_serial_ripple_subtractor;

   localparam int unsigned N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] diff;
   logic         bout;

   int errors = 0;
   int checks = 0;

   serial_ripple_subtractor #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
   );

   always #5 clk = ~clk;

   function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                        input logic bi);
      return {1'b0, x} - {1'b0, y} - (N+1)'(bi);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one operation end to end; returns captured result, latency and post-handshake valid.
   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                         input int stall, input bit junk,
                         output logic [N-1:0] dq, output logic bq, output int lat,
                         output logic ov_after);
      int w;
      in_valid = 1'b1;
      a = av;
      b = bv;
      bin = bi;
      w = 0;
      while (!in_ready && w < 100) begin
         tick();
         w++;
      end
      tick();
      in_valid = junk;
      a = N'($urandom);
      b = N'($urandom);
      bin = 1'($urandom);
      lat = 0;
      for (int k = 1; k <= int'(N) + 8; k++) begin
         tick();
         if (junk) begin
            a = N'($urandom);
            b = N'($urandom);
         end
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      in_valid = 1'b0;
      dq = diff;
      bq = bout;
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      ov_after = out_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      bin = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if ({bout, diff} !== 17'h0) begin
         errors++;
         $display("FAIL reset_result: got %h expected 0", {bout, diff});
      end
   endtask

   task automatic test_directed();
      logic [N-1:0] ta [4] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h0000};
      logic [N-1:0] tb [4] = '{16'hFFFF, 16'h0000, 16'h1234, 16'h0000};
      logic         tbi[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [N-1:0] ed [4] = '{16'h0001, 16'hFFFE, 16'h0000, 16'hFFFF};
      logic         eb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [N-1:0] dq;
      logic         bq, ova;
      int           lat;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], tbi[i], 0, 1'b0, dq, bq, lat, ova);
         checks++;
         if (dq !== ed[i]) begin
            errors++;
            $display("FAIL directed_diff[%0d]: got %h expected %h", i, dq, ed[i]);
         end
         checks++;
         if (bq !== eb[i]) begin
            errors++;
            $display("FAIL directed_bout[%0d]: got %b expected %b", i, bq, eb[i]);
         end
         checks++;
         if (lat != int'(N)) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, N);
         end
         checks++;
         if (ova !== 1'b0) begin
            errors++;
            $display("FAIL directed_valid_drop[%0d]: got %b expected 0", i, ova);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] av = 16'hA5C3;
      logic [N-1:0] bv = 16'hC3A5;
      logic [N:0]   exp_r = model(av, bv, 1'b1);
      int           w;
      in_valid = 1'b1;
      a = av;
      b = bv;
      bin = 1'b1;
      tick();
      // Different operands pulsed while running must not disturb the result.
      a = 16'h1111;
      b = 16'h2222;
      bin = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 40) begin
         tick();
         w++;
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, bout, diff} !== {1'b1, exp_r}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b %h expected v=1 %h", i, out_valid,
                     {bout, diff}, exp_r);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] dq;
      logic         bq, ova;
      int           lat;
      in_valid = 1'b1;
      a = 16'h5555;
      b = 16'h0F0F;
      bin = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_state: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
      end
      run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, dq, bq, lat, ova);
      checks++;
      if ({bq, dq} !== 17'h07FFF) begin
         errors++;
         $display("FAIL midrst_after: got %h expected 07fff", {bq, dq});
      end
      checks++;
      if (lat != int'(N)) begin
         errors++;
         $display("FAIL midrst_latency: got %0d expected %0d", lat, N);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] av = 16'h0100;
      logic [N-1:0] bv = 16'h0200;
      logic [N:0]   exp_r = model(av, bv, 1'b0);
      int           seen, last, cyc;
      in_valid = 1'b1;
      out_ready = 1'b1;
      a = av;
      b = bv;
      bin = 1'b0;
      seen = 0;
      last = 0;
      cyc = 0;
      while (seen < 4 && cyc < 200) begin
         tick();
         cyc++;
         if (out_valid) begin
            checks++;
            if ({bout, diff} !== exp_r) begin
               errors++;
               $display("FAIL b2b_result[%0d]: got %h expected %h", seen, {bout, diff}, exp_r);
            end
            if (seen > 0) begin
               checks++;
               if (cyc - last != int'(N) + 2) begin
                  errors++;
                  $display("FAIL b2b_period[%0d]: got %0d expected %0d", seen, cyc - last, N + 2);
               end
            end
            last = cyc;
            seen++;
         end
      end
      checks++;
      if (seen != 4) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d results expected 4", seen);
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [N-1:0] av, bv, dq;
      logic         bi, bq, ova;
      logic [N:0]   exp_r;
      int           lat;
      for (int i = 0; i < 1000; i++) begin
         av = N'($urandom);
         bv = N'($urandom);
         bi = 1'($urandom);
         if (i % 8 == 0) bv = av;
         exp_r = model(av, bv, bi);
         run_op(av, bv, bi, int'($urandom_range(0, 3)), 1'($urandom), dq, bq, lat, ova);
         checks++;
         if ({bq, dq} !== exp_r) begin
            errors++;
            $display("FAIL rand_result[%0d]: a=%h b=%h bin=%b got %h expected %h", i, av, bv,
                     bi, {bq, dq}, exp_r);
         end
         checks++;
         if (lat != int'(N)) begin
            errors++;
            $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, N);
         end
         checks++;
         if (ova !== 1'b0) begin
            errors++;
            $display("FAIL rand_valid_drop[%0d]: got %b expected 0", i, ova);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
